// File: rtl/cdb_arbiter_pkg.sv
// CDB arbiter shared types and defaults.
// Entry layout is what each producer FIFO stores.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ    = 2;
    localparam int CDB_FIFO_DEPTH = 2;
    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int ROBID_W        = 4;

    typedef struct packed {
        logic [DATA_W-1:0]  result;
        logic [ADDR_W-1:0]  new_pc;
        logic [ROBID_W-1:0] rob_id;
    } cdb_entry_t;

    function automatic int src_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer request bus and CDB broadcast bus.
// master = producer/consumer side, slave = arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
);
    localparam int SRC_W = src_width(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid_in;
    logic [NUM_REQ*DATA_W-1:0]  req_result_in;
    logic [NUM_REQ*ADDR_W-1:0]  req_new_pc_in;
    logic [NUM_REQ*ROBID_W-1:0] req_rob_id_in;
    logic [NUM_REQ-1:0]         req_ready_out;
    logic                       rdy_cdb_out;
    logic [DATA_W-1:0]          result_cdb_out;
    logic [ADDR_W-1:0]          new_pc_cdb_out;
    logic [ROBID_W-1:0]         rob_id_cdb_out;
    logic [SRC_W-1:0]           src_cdb_out;
    logic                       busy_out;

    modport master (
        output req_valid_in, req_result_in,
        output req_new_pc_in, req_rob_id_in,
        input  req_ready_out, rdy_cdb_out,
        input  result_cdb_out, new_pc_cdb_out,
        input  rob_id_cdb_out, src_cdb_out,
        input  busy_out
    );

    modport slave (
        input  req_valid_in, req_result_in,
        input  req_new_pc_in, req_rob_id_in,
        output req_ready_out, rdy_cdb_out,
        output result_cdb_out, new_pc_cdb_out,
        output rob_id_cdb_out, src_cdb_out,
        output busy_out
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-producer result FIFO; power-of-two depth so
// pointers wrap naturally.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  cdb_entry_t       din,
    output cdb_entry_t       dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= din;
    end

    assign dout  = mem[head];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus
// between buffered result producers.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input logic         clk_in,
    input logic         rst_in,
    input logic         rdy_in,
    input logic         refresh_rob_cdb_in,
    cdb_arbiter_if.slave bus
);

    localparam int SRC_W = src_width(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic               enq_ok;
    logic               flush;
    cdb_entry_t         head  [NUM_REQ];
    logic [CNT_W-1:0]   count [NUM_REQ];
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;

    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   win;
    logic               win_vld;

    logic               cdb_vld;
    cdb_entry_t         cdb_data;
    logic [SRC_W-1:0]   cdb_src;
    logic               busy;

    assign enq_ok = rdy_in && !refresh_rob_cdb_in;
    assign flush  = rdy_in && refresh_rob_cdb_in;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cdb_entry_t din;

        assign din.result = bus.req_result_in[g*DATA_W +: DATA_W];
        assign din.new_pc = bus.req_new_pc_in[g*ADDR_W +: ADDR_W];
        assign din.rob_id = bus.req_rob_id_in[g*ROBID_W +: ROBID_W];

        assign ready[g] = enq_ok && !full[g];
        assign push[g]  = bus.req_valid_in[g] && ready[g];
        assign pop[g]   = enq_ok && win_vld
                          && (win == SRC_W'(g));

        cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk_in),
            .rst   (rst_in),
            .flush (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din),
            .dout  (head[g]),
            .count (count[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Scan walked backwards so the nearest candidate
    // after last_grant is the final (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!empty[idx]) begin
                win_vld = 1'b1;
                win     = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        busy = cdb_vld;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (count[i] != '0) busy = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cdb_vld    <= 1'b0;
            cdb_data   <= '0;
            cdb_src    <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
        end else if (rdy_in) begin
            if (refresh_rob_cdb_in) begin
                cdb_vld    <= 1'b0;
                last_grant <= SRC_W'(NUM_REQ - 1);
            end else if (win_vld) begin
                cdb_vld    <= 1'b1;
                cdb_data   <= head[win];
                cdb_src    <= win;
                last_grant <= win;
            end else begin
                cdb_vld    <= 1'b0;
            end
        end
    end

    assign bus.req_ready_out  = ready;
    assign bus.rdy_cdb_out    = cdb_vld;
    assign bus.result_cdb_out = cdb_data.result;
    assign bus.new_pc_cdb_out = cdb_data.new_pc;
    assign bus.rob_id_cdb_out = cdb_data.rob_id;
    assign bus.src_cdb_out    = cdb_src;
    assign bus.busy_out       = busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against
// a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = CDB_NUM_REQ;
    localparam int D = CDB_FIFO_DEPTH;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] p;
        logic [3:0]  t;
    } ent_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    logic refresh_rob_cdb_in = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .refresh_rob_cdb_in (refresh_rob_cdb_in),
        .bus                (bus)
    );

    always #5 clk_in = ~clk_in;

    // reference model state
    ent_t mq [N][$];
    int   lg;
    logic ev;
    ent_t eo;
    int   es;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mq[i]) mq[i].delete();
        lg = N - 1;
        ev = 1'b0;
        eo = '0;
        es = 0;
    endtask

    function automatic logic [N-1:0] model_ready(logic rdy, logic rf);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = rdy && !rf && (mq[i].size() < D);
        return r;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = ev;
        for (int i = 0; i < N; i++)
            if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.r = $urandom;
        e.p = $urandom;
        e.t = 4'($urandom_range(0, 15));
        return e;
    endfunction

    task automatic check_outs(input string tag);
        check({tag, ".vld"},  64'(bus.rdy_cdb_out),    64'(ev));
        check({tag, ".res"},  64'(bus.result_cdb_out), 64'(eo.r));
        check({tag, ".pc"},   64'(bus.new_pc_cdb_out), 64'(eo.p));
        check({tag, ".rob"},  64'(bus.rob_id_cdb_out), 64'(eo.t));
        check({tag, ".src"},  64'(bus.src_cdb_out),    64'(es));
        check({tag, ".busy"}, 64'(bus.busy_out),       64'(model_busy()));
    endtask

    // One clock: drive at negedge, check ready, update model at posedge,
    // check registered outputs just after it, return at next negedge.
    task automatic step(input logic [N-1:0] v, input ent_t e0,
                        input ent_t e1, input logic rdy, input logic rf,
                        output logic [N-1:0] acc);
        ent_t         ein [N];
        logic [N-1:0] er;
        int           w;
        int           idx;
        ein[0] = e0;
        ein[1] = e1;
        rdy_in = rdy;
        refresh_rob_cdb_in = rf;
        bus.req_valid_in = v;
        for (int i = 0; i < N; i++) begin
            bus.req_result_in[i*32 +: 32] = ein[i].r;
            bus.req_new_pc_in[i*32 +: 32] = ein[i].p;
            bus.req_rob_id_in[i*4 +: 4]   = ein[i].t;
        end
        #1;
        er = model_ready(rdy, rf);
        check("ready", 64'(bus.req_ready_out), 64'(er));
        acc = v & er;
        @(posedge clk_in);
        if (rdy) begin
            if (rf) begin
                foreach (mq[i]) mq[i].delete();
                ev = 1'b0;
                lg = N - 1;
            end else begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (lg + k) % N;
                    if (w < 0 && mq[idx].size() > 0) w = idx;
                end
                if (w >= 0) begin
                    eo = mq[w].pop_front();
                    ev = 1'b1;
                    es = w;
                    lg = w;
                end else begin
                    ev = 1'b0;
                end
                for (int i = 0; i < N; i++)
                    if (acc[i]) mq[i].push_back(ein[i]);
            end
        end
        #1;
        check_outs("cyc");
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        logic [N-1:0] a;
        for (int i = 0; i < n; i++)
            step('0, rnd_ent(), rnd_ent(), 1'b1, 1'b0, a);
    endtask

    // Asynchronous reset asserted between edges, released at a negedge.
    task automatic do_reset();
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        check_outs("rst_async");
        @(posedge clk_in);
        @(negedge clk_in);
        bus.req_valid_in = '0;
        rdy_in = 1'b1;
        refresh_rob_cdb_in = 1'b0;
        rst_in = 1'b0;
        #1;
        check("rst_ready", 64'(bus.req_ready_out), 64'h3);
        @(negedge clk_in);
    endtask

    initial begin
        logic [N-1:0] acc;
        ent_t         e;
        ent_t         a_e;
        ent_t         l_e;
        int           ai;
        int           li;
        int           nb;
        int           stalled;
        logic [3:0]   tags [8];
        int           cycs [8];
        logic [3:0]   exp_tags [6];
        logic [3:0]   lsb_tags [3];
        logic         rdy;
        logic         rf;

        exp_tags = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
        lsb_tags = '{4'd5, 4'd6, 4'd7};
        bus.req_valid_in  = '0;
        bus.req_result_in = '0;
        bus.req_new_pc_in = '0;
        bus.req_rob_id_in = '0;
        model_reset();
        #1 rst_in = 1'b1;
        @(negedge clk_in);
        check_outs("reset");
        rst_in = 1'b0;
        rdy_in = 1'b1;

        // single ALU result: visible only after the second edge
        e = '{r: 32'h5, p: 32'h100, t: 4'd3};
        step(2'b01, e, rnd_ent(), 1'b1, 1'b0, acc);
        check("alu_e0_vld", 64'(bus.rdy_cdb_out), 64'h0);
        step(2'b00, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        check("alu_e1_vld", 64'(bus.rdy_cdb_out), 64'h1);
        check("alu_e1_res", 64'(bus.result_cdb_out), 64'h5);
        check("alu_e1_rob", 64'(bus.rob_id_cdb_out), 64'h3);
        check("alu_e1_src", 64'(bus.src_cdb_out), 64'h0);
        idle(2);

        // some traffic, then reset in the middle of it
        for (int i = 0; i < 4; i++)
            step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        do_reset();

        // contention: producers hold each result until accepted
        ai = 0; li = 0; nb = 0;
        for (int c = 0; c < 16; c++) begin
            a_e = rnd_ent(); a_e.t = exp_tags[2*(ai < 3 ? ai : 0)];
            l_e = rnd_ent(); l_e.t = exp_tags[2*(li < 3 ? li : 0) + 1];
            step({li < 3, ai < 3}, a_e, l_e, 1'b1, 1'b0, acc);
            ai += int'(acc[0]);
            li += int'(acc[1]);
            if (bus.rdy_cdb_out && nb < 8) begin
                tags[nb] = bus.rob_id_cdb_out;
                cycs[nb] = c;
                nb++;
            end
        end
        check("cont_count", 64'(nb), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < nb) begin
                check("cont_tag", 64'(tags[k]), 64'(exp_tags[k]));
                check("cont_gap", 64'(cycs[k] - cycs[0]), 64'(k));
            end
        end

        // backpressure: ALU always offering, LSB pushes 3 in a row
        do_reset();
        li = 0; nb = 0; stalled = 0;
        for (int c = 0; c < 14; c++) begin
            l_e = rnd_ent();
            l_e.t = lsb_tags[li < 3 ? li : 2];
            step({li < 3, c < 10}, rnd_ent(), l_e, 1'b1, 1'b0, acc);
            if (li < 3 && !acc[1]) stalled++;
            li += int'(acc[1]);
            if (bus.rdy_cdb_out && bus.src_cdb_out == 1'b1 && nb < 3) begin
                check("bp_order", 64'(bus.rob_id_cdb_out), 64'(lsb_tags[nb]));
                nb++;
            end
        end
        check("bp_stalled", 64'(stalled > 0), 64'h1);
        check("bp_lsb_acc", 64'(li), 64'd3);
        check("bp_lsb_out", 64'(nb), 64'd3);
        idle(6);

        // refresh with three entries buffered and a valid in that cycle
        step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b1, acc);
        check("rf_vld", 64'(bus.rdy_cdb_out), 64'h0);
        check("rf_busy", 64'(bus.busy_out), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step('0, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
            check("rf_quiet", 64'(bus.rdy_cdb_out), 64'h0);
        end

        // stall with FIFOs non-empty
        step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        step(2'b11, rnd_ent(), rnd_ent(), 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++)
            step(2'($urandom), rnd_ent(), rnd_ent(), 1'b0,
                 1'($urandom), acc);
        idle(6);

        // long random run
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            rf  = ($urandom_range(0, 24) == 0);
            step(2'($urandom), rnd_ent(), rnd_ent(), rdy, rf, acc);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
